// File: rtl/moore_serial_tx_pkg.sv
// Shared definitions for the moore_serial_tx serial transmitter.
// State encoding and fixed line levels used by the FSM and its output decode.
package moore_serial_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/moore_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYC-1, raises tick on the last cycle of
// each serial bit and wraps to 0. clr holds the count at 0 between frames.
module moore_bit_timer
   import moore_serial_tx_pkg::*;
#(
   parameter int BIT_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = $clog2(BIT_CYC) + 1;
   localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // Cycle counter, wrapping on every bit boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/moore_serial_tx.sv
// Moore serial transmitter: start(0), DATA_W data bits LSB first, optional
// even parity, stop(1); each bit held BIT_CYC clocks. qout is registered from
// state and datapath registers only, so it lags the state by one clock.
// Optional feature macro: MOORE_TX_PARITY_EN (adds the even-parity bit).
module moore_serial_tx
   import moore_serial_tx_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int BIT_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              qout,
   output logic              busy
);

   localparam int            BW    = $clog2(DATA_W) + 1;
   localparam logic [BW-1:0] LASTB = BW'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [BW-1:0]     bitcnt;
   logic              tick;
   logic              xfer;
`ifdef MOORE_TX_PARITY_EN
   logic              par;
`endif

   // Ready and busy are pure state decodes: no path from din_valid.
   assign din_ready = (state == S_IDLE);
   assign busy      = ~din_ready;
   assign xfer      = din_valid & din_ready;

   moore_bit_timer #(.BIT_CYC(BIT_CYC)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (din_ready),
      .tick (tick)
   );

   // Frame sequencer: state, bit counter, shift register and latched parity.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         shreg  <= '0;
         bitcnt <= '0;
`ifdef MOORE_TX_PARITY_EN
         par    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer) begin
                  shreg <= din;
`ifdef MOORE_TX_PARITY_EN
                  par   <= ^din;
`endif
                  state <= S_START;
               end
            end
            S_START: begin
               if (tick) state <= S_DATA;
            end
            S_DATA: begin
               if (tick) begin
                  shreg <= shreg >> 1;
                  if (bitcnt == LASTB) begin
                     bitcnt <= '0;
`ifdef MOORE_TX_PARITY_EN
                     state  <= S_PARITY;
`else
                     state  <= S_STOP;
`endif
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                  end
               end
            end
`ifdef MOORE_TX_PARITY_EN
            S_PARITY: begin
               if (tick) state <= S_STOP;
            end
`endif
            S_STOP: begin
               if (tick) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Registered line level decoded from the current state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qout <= IDLE_LVL;
      end else begin
         case (state)
            S_START:  qout <= START_LVL;
            S_DATA:   qout <= shreg[0];
`ifdef MOORE_TX_PARITY_EN
            S_PARITY: qout <= par;
`endif
            S_STOP:   qout <= STOP_LVL;
            default:  qout <= IDLE_LVL;
         endcase
      end
   end

endmodule

// File: tb/tb_moore_serial_tx.sv
// Self-checking bench for moore_serial_tx: table of frames on a BIT_CYC=4
// instance, hand sequences for reset, back-to-back and BIT_CYC=1.
module tb_moore_serial_tx;

`ifdef MOORE_TX_PARITY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif
   localparam int BC = 4;
   localparam int NB = 10 + PEN;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       din_ready, qout, busy;
   logic [7:0] din1 = '0;
   logic       din_valid1 = 1'b0;
   logic       din_ready1, qout1, busy1;

   always #5 clk = ~clk;

   moore_serial_tx #(.DATA_W(8), .BIT_CYC(BC)) u_dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .qout(qout), .busy(busy)
   );

   moore_serial_tx #(.DATA_W(8), .BIT_CYC(1)) u_dut1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1),
      .din_ready(din_ready1), .qout(qout1), .busy(busy1)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // fr: full 10-bit frame in send order (bit 9 first): start, data LSB first, stop.
   typedef struct {
      logic [7:0] din;
      logic [9:0] fr;
      logic       p;
   } vec_t;

   vec_t tbl [7];

   // Called at the negedge right after the transfer edge; follows the whole frame.
   task automatic check_frame(input string nm, input logic [9:0] fr, input logic p);
      int   busy_n;
      int   rdy_n;
      logic eb;
      logic ok;
      chk({nm, " latency qout"}, {31'd0, qout}, 32'd1);
      busy_n = busy ? 1 : 0;
      rdy_n  = din_ready ? 1 : 0;
      for (int k = 0; k < NB; k++) begin
         if (k < 9)            eb = fr[9-k];
         else if (k == NB - 1) eb = fr[0];
         else                  eb = p;
         ok = 1'b1;
         for (int c = 0; c < BC; c++) begin
            @(negedge clk);
            if (qout !== eb) ok = 1'b0;
            if (busy)        busy_n++;
            if (din_ready)   rdy_n++;
         end
         chk($sformatf("%s bit%0d level ok (want %0b)", nm, k, eb), {31'd0, ok}, 32'd1);
      end
      chk({nm, " busy cycles"}, busy_n, NB * BC);
      chk({nm, " ready pulses"}, rdy_n, 1);
   endtask

   // Handshake one word, then scramble din and drop valid to prove it was latched.
   task automatic send(input logic [7:0] d);
      int t;
      t = 0;
      @(negedge clk);
      while (!din_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("ready before send", {31'd0, din_ready}, 32'd1);
      din       = d;
      din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din       = ~d;
      din_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
      tbl[1] = '{8'h07, 10'b0111000001, 1'b1};
      tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
      tbl[3] = '{8'h00, 10'b0000000001, 1'b0};
      tbl[4] = '{8'h3C, 10'b0001111001, 1'b0};
      tbl[5] = '{8'h81, 10'b0100000011, 1'b0};
      tbl[6] = '{8'h80, 10'b0000000011, 1'b1};

      // Reset with clock running.
      repeat (3) @(negedge clk);
      chk("reset qout",      {31'd0, qout},      32'd1);
      chk("reset din_ready", {31'd0, din_ready}, 32'd1);
      chk("reset busy",      {31'd0, busy},      32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle qout", {31'd0, qout}, 32'd1);

      // Table of single frames.
      for (int i = 0; i < 7; i++) begin
         send(tbl[i].din);
         check_frame($sformatf("frame%0d_%02h", i, tbl[i].din), tbl[i].fr, tbl[i].p);
      end

      // Reset mid-frame: line returns high asynchronously, word is dropped.
      send(8'hA5);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midreset qout",      {31'd0, qout},      32'd1);
      chk("midreset busy",      {31'd0, busy},      32'd0);
      chk("midreset din_ready", {31'd0, din_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("post-reset qout idle", {31'd0, qout}, 32'd1);
      chk("post-reset busy",      {31'd0, busy}, 32'd0);

      // Back-to-back with din_valid held high: FF then 00.
      @(negedge clk);
      din       = 8'hFF;
      din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din = 8'h00;
      check_frame("b2b_ff", 10'b0111111111, 1'b0);
      @(negedge clk);
      din_valid = 1'b0;
      chk("b2b busy after gap", {31'd0, busy}, 32'd1);
      check_frame("b2b_00", 10'b0000000001, 1'b0);

      // BIT_CYC=1: one bit per clock.
      @(negedge clk);
      din1       = 8'h00;
      din_valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_valid1 = 1'b0;
      din1       = 8'hFF;
      chk("bc1 latency qout", {31'd0, qout1}, 32'd1);
      for (int k = 0; k < NB; k++) begin
         @(negedge clk);
         chk($sformatf("bc1 bit%0d", k), {31'd0, qout1}, (k == NB - 1) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      chk("bc1 idle qout", {31'd0, qout1}, 32'd1);
      chk("bc1 idle busy", {31'd0, busy1}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
